pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_dec.sv | 66 ++++++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - MIPS opcode constants used by the field decoder
//   - operand-forwarding select encodings driven on fwd_a / fwd_b
//   - slot_t: one entry of the shadow pipeline (EX, MEM, WB)
//   - slot_hit(): does a shadow slot produce a given register
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   // Upper opcode bits shared by the immediate ALU group (addi .. lui).
   localparam logic [2:0] OP_IMM_HI = 3'b001;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } slot_t;

   localparam slot_t SLOT_NONE = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

   function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
      return s.valid && (s.dest == r);
   endfunction

endpackage

// File: rtl/pipe_dec.sv
// pipe_dec: purely combinational field decode of the instruction in ID.
// Ports:
//   ir         - 32-bit instruction word
//   dest       - destination register (rd, rt or 31 depending on class)
//   dest_valid - instruction writes a register other than $0
//   is_load    - instruction is LW (result only available after MEM)
//   use_rs     - instruction reads rs
//   use_rt     - instruction reads rt
module pipe_dec
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [4:0]  dest,
   output logic        dest_valid,
   output logic        is_load,
   output logic        use_rs,
   output logic        use_rt
);

   logic [5:0] op;
   logic       has_dest;

   always_comb begin
      op       = ir[31:26];
      dest     = 5'd0;
      has_dest = 1'b0;
      is_load  = 1'b0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      if (op == OP_RTYPE) begin
         dest     = ir[15:11];
         has_dest = 1'b1;
         use_rs   = 1'b1;
         use_rt   = 1'b1;
      end else if (op[5:3] == OP_IMM_HI) begin
         dest     = ir[20:16];
         has_dest = 1'b1;
         use_rs   = 1'b1;
      end else begin
         case (op)
            OP_LW: begin
               dest     = ir[20:16];
               has_dest = 1'b1;
               is_load  = 1'b1;
               use_rs   = 1'b1;
            end
            OP_JAL: begin
               dest     = 5'd31;
               has_dest = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
               use_rs = 1'b1;
               use_rt = 1'b1;
            end
            default: ;
         endcase
      end
      // $0 is hard-wired, so writing it never creates a dependency.
      dest_valid = has_dest && (dest != 5'd0);
   end

   // rs/rt are extracted by the controller; low immediate bits carry no decode info.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[25:21], ir[10:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection, stall/flush control and operand forwarding
// select for a classic 5-stage MIPS pipeline.
// Optional feature: define PIPE_CTRL_FWD_EN to build in EX/MEM and MEM/WB
// forwarding (only load-use stalls remain). Without it fwd_a/fwd_b are tied
// to the register file and any dependency on EX or MEM stalls.
// Ports:
//   clk, rst     - clock; asynchronous active-high reset
//   id_ir        - instruction in ID;  id_valid - it is not a bubble
//   ex_cond      - branch/jump in EX is taken this cycle
//   pc_we        - PC write enable;     ifid_we - IF/ID write enable
//   idex_bubble  - load NOP into ID/EX; ifid_flush - clear IF/ID
//   fwd_a, fwd_b - EX operand select (00 RF, 01 EX/MEM ALUo, 10 MEM/WB)
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_ir,
   input  logic        id_valid,
   input  logic        ex_cond,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b
);

   logic [4:0] dec_dest;
   logic       dec_dest_valid;
   logic       dec_is_load;
   logic       dec_use_rs;
   logic       dec_use_rt;

   pipe_dec u_dec (
      .ir         (id_ir),
      .dest       (dec_dest),
      .dest_valid (dec_dest_valid),
      .is_load    (dec_is_load),
      .use_rs     (dec_use_rs),
      .use_rt     (dec_use_rt)
   );

   logic [4:0] rs;
   logic [4:0] rt;
   assign rs = id_ir[25:21];
   assign rt = id_ir[20:16];

   slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

   logic hz_ex_rs, hz_ex_rt, hz_mem_rs, hz_mem_rt;
   logic stall;
   logic enter;

   always_comb begin
      hz_ex_rs  = id_valid && dec_use_rs && slot_hit(ex_q, rs);
      hz_ex_rt  = id_valid && dec_use_rt && slot_hit(ex_q, rt);
      hz_mem_rs = id_valid && dec_use_rs && slot_hit(mem_q, rs);
      hz_mem_rt = id_valid && dec_use_rt && slot_hit(mem_q, rt);
`ifdef PIPE_CTRL_FWD_EN
      // Only a load in EX cannot be forwarded in time.
      stall = ex_q.is_load && (hz_ex_rs || hz_ex_rt);
`else
      stall = hz_ex_rs || hz_ex_rt || hz_mem_rs || hz_mem_rt;
`endif
      // A taken branch kills the ID instruction, so a coincident stall is moot.
      enter = id_valid && !stall && !ex_cond;
   end

   always_comb begin
      ex_d = SLOT_NONE;
      if (enter) begin
         ex_d = '{valid: dec_dest_valid, dest: dec_dest, is_load: dec_is_load};
      end
      mem_d = ex_q;
      wb_d  = mem_q;
   end

   // Outputs follow rst combinationally so the pipe is frozen during reset.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else if (ex_cond) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= SLOT_NONE;
         mem_q <= SLOT_NONE;
         wb_q  <= SLOT_NONE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef PIPE_CTRL_FWD_EN
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

   // Selects are captured as the ID instruction moves into EX: the current
   // EX producer then sits in EX/MEM and the MEM producer in MEM/WB. A WB
   // producer needs nothing since the register file is write-through.
   always_comb begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (enter) begin
         if (hz_ex_rs)       fwd_a_d = FWD_EXMEM;
         else if (hz_mem_rs) fwd_a_d = FWD_MEMWB;
         if (hz_ex_rt)       fwd_b_d = FWD_EXMEM;
         else if (hz_mem_rt) fwd_b_d = FWD_MEMWB;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

   // WB slot is tracked for completeness but never needs action.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{wb_q, mem_q.is_load, ex_q.is_load};

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] id_ir;
   logic        id_valid;
   logic        ex_cond;
   logic        pc_we;
   logic        ifid_we;
   logic        idex_bubble;
   logic        ifid_flush;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;

   pipe_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_ir       (id_ir),
      .id_valid    (id_valid),
      .ex_cond     (ex_cond),
      .pc_we       (pc_we),
      .ifid_we     (ifid_we),
      .idex_bubble (idex_bubble),
      .ifid_flush  (ifid_flush),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );

   always #5 clk = ~clk;

`ifdef PIPE_CTRL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [31:0] I_ADD1 = 32'h00221820; // add $3,$1,$2
   localparam logic [31:0] I_SUB  = 32'h00612022; // sub $4,$3,$1
   localparam logic [31:0] I_LW   = 32'h8C250000; // lw  $5,0($1)
   localparam logic [31:0] I_ADD2 = 32'h00A23020; // add $6,$5,$2
   localparam logic [31:0] I_ADD0 = 32'h00220020; // add $0,$1,$2
   localparam logic [31:0] I_RD0  = 32'h00002020; // add $4,$0,$0
   localparam logic [31:0] I_JAL  = 32'h0C000000; // jal 0
   localparam logic [31:0] I_JR   = 32'h03E00008; // jr  $31
   localparam logic [31:0] I_ADDI = 32'h20270005; // addi $7,$1,5
   localparam logic [31:0] I_BEQ  = 32'h10E00003; // beq $7,$0

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // prod[0] = producer in EX, prod[1] = MEM, prod[2] = WB; dest -1 = none.
   typedef struct {
      int dest;
      bit load;
   } mslot_t;

   mslot_t     prod[$];
   logic [1:0] m_fa, m_fb;

   function automatic void mdec(input logic [31:0] ir, output int dst, output bit ld,
                                output bit urs, output bit urt);
      int op;
      op  = int'(ir[31:26]);
      dst = -1; ld = 0; urs = 0; urt = 0;
      if (op == 0) begin
         dst = int'(ir[15:11]); urs = 1; urt = 1;
      end else if (op >= 8 && op <= 15) begin
         dst = int'(ir[20:16]); urs = 1;
      end else if (op == 35) begin
         dst = int'(ir[20:16]); ld = 1; urs = 1;
      end else if (op == 43 || op == 4 || op == 5) begin
         urs = 1; urt = 1;
      end else if (op == 3) begin
         dst = 31;
      end
      if (dst == 0) dst = -1;
   endfunction

   function automatic bit reads(input int d, input bit urs, input bit urt, input int rs, input int rt);
      return (d >= 0) && ((urs && rs == d) || (urt && rt == d));
   endfunction

   function automatic void meval(output bit stall, output logic [1:0] fa, output logic [1:0] fb);
      int d, rs, rt;
      bit ld, urs, urt;
      stall = 0; fa = 2'b00; fb = 2'b00;
      if (id_valid !== 1'b1) return;
      mdec(id_ir, d, ld, urs, urt);
      rs = int'(id_ir[25:21]);
      rt = int'(id_ir[20:16]);
      if (FWD) begin
         stall = prod[0].load && reads(prod[0].dest, urs, urt, rs, rt);
         if (urs && prod[0].dest == rs)      fa = 2'b01;
         else if (urs && prod[1].dest == rs) fa = 2'b10;
         if (urt && prod[0].dest == rt)      fb = 2'b01;
         else if (urt && prod[1].dest == rt) fb = 2'b10;
      end else begin
         stall = reads(prod[0].dest, urs, urt, rs, rt) || reads(prod[1].dest, urs, urt, rs, rt);
      end
   endfunction

   function automatic bit model_stall();
      bit s;
      logic [1:0] a, b;
      meval(s, a, b);
      return s;
   endfunction

   task automatic model_clear();
      mslot_t none_s;
      none_s.dest = -1;
      none_s.load = 0;
      prod.delete();
      repeat (3) prod.push_back(none_s);
      m_fa = 2'b00;
      m_fb = 2'b00;
   endtask

   bit         mu_st, mu_ld, mu_urs, mu_urt;
   logic [1:0] mu_fa, mu_fb;
   int         mu_d;
   mslot_t     mu_new;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_clear();
      end else begin
         meval(mu_st, mu_fa, mu_fb);
         mu_new.dest = -1;
         mu_new.load = 0;
         if (id_valid && !mu_st && !ex_cond) begin
            mdec(id_ir, mu_d, mu_ld, mu_urs, mu_urt);
            mu_new.dest = mu_d;
            mu_new.load = mu_ld;
            m_fa = mu_fa;
            m_fb = mu_fb;
         end else begin
            m_fa = 2'b00;
            m_fb = 2'b00;
         end
         prod.push_front(mu_new);
         void'(prod.pop_back());
      end
   end

   // ---------------- per-cycle compare ----------------
   bit         cp_st;
   logic [1:0] cp_fa, cp_fb;
   logic       e_pc, e_if, e_bub, e_fl;

   always @(negedge clk) begin
      if (prod.size() == 3) begin
         cp_st = 0;
         if (!rst) meval(cp_st, cp_fa, cp_fb);
         e_pc = 1; e_if = 1; e_bub = 0; e_fl = 0;
         if (rst) begin
            e_pc = 0; e_if = 0; e_bub = 1;
         end else if (ex_cond) begin
            e_fl = 1; e_bub = 1;
         end else if (cp_st) begin
            e_pc = 0; e_if = 0; e_bub = 1;
         end
         chk("cyc pc_we", 32'(pc_we), 32'(e_pc));
         if (rst || !ex_cond) chk("cyc ifid_we", 32'(ifid_we), 32'(e_if));
         chk("cyc idex_bubble", 32'(idex_bubble), 32'(e_bub));
         chk("cyc ifid_flush", 32'(ifid_flush), 32'(e_fl));
         chk("cyc fwd_a", 32'(fwd_a), 32'(m_fa));
         chk("cyc fwd_b", 32'(fwd_b), 32'(m_fb));
      end
   end

   // ---------------- stimulus ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      id_valid = 0;
      ex_cond  = 0;
      repeat (n) sync();
   endtask

   // Hold an instruction in ID until it is accepted into EX; returns stall cycles.
   task automatic present(input logic [31:0] ir, output int stalls);
      bit st, done;
      id_ir    = ir;
      id_valid = 1;
      stalls   = 0;
      done     = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         st = model_stall();
         sync();
         if (!st) begin
            done = 1;
            break;
         end
         stalls++;
      end
      if (!done) chk("present timeout", 32'(done), 32'd1);
      id_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int s;

   initial begin
      clk = 0; rst = 0; id_ir = 32'h0; id_valid = 0; ex_cond = 0;
      model_clear();
      #1 rst = 1;
      @(negedge clk);
      chk("reset pc_we", 32'(pc_we), 32'd0);
      chk("reset ifid_we", 32'(ifid_we), 32'd0);
      chk("reset bubble", 32'(idex_bubble), 32'd1);
      chk("reset flush", 32'(ifid_flush), 32'd0);
      chk("reset fwd_a", 32'(fwd_a), 32'd0);
      sync();
      rst = 0;
      @(negedge clk);
      chk("idle pc_we", 32'(pc_we), 32'd1);
      chk("idle bubble", 32'(idex_bubble), 32'd0);
      sync();

      // ALU producer followed by dependent ALU consumer
      present(I_ADD1, s);
      chk("add1 stalls", 32'(s), 32'd0);
      present(I_SUB, s);
      chk("sub stalls", 32'(s), FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      chk("sub fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
      chk("sub fwd_b", 32'(fwd_b), 32'd0);
      sync(); idle(3);

      // load-use
      present(I_LW, s);
      present(I_ADD2, s);
      chk("loaduse stalls", 32'(s), FWD ? 32'd1 : 32'd2);
      @(negedge clk);
      chk("loaduse fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
      sync(); idle(3);

      // taken branch while ID holds the load-use consumer
      present(I_LW, s);
      id_ir = I_ADD2; id_valid = 1; ex_cond = 1;
      @(negedge clk);
      chk("flush ifid_flush", 32'(ifid_flush), 32'd1);
      chk("flush bubble", 32'(idex_bubble), 32'd1);
      chk("flush pc_we", 32'(pc_we), 32'd1);
      sync();
      ex_cond = 0;
      present(I_ADD2, s);
      chk("post-flush stalls", 32'(s), FWD ? 32'd0 : 32'd1);
      @(negedge clk);
      chk("post-flush fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
      sync(); idle(3);

      // $0 destination creates no dependency
      present(I_ADD0, s);
      present(I_RD0, s);
      chk("r0 stalls", 32'(s), 32'd0);
      @(negedge clk);
      chk("r0 fwd_a", 32'(fwd_a), 32'd0);
      chk("r0 fwd_b", 32'(fwd_b), 32'd0);
      sync(); idle(3);

      // JAL writes $31
      present(I_JAL, s);
      present(I_JR, s);
      chk("jal stalls", 32'(s), FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      chk("jal fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
      sync(); idle(3);

      // immediate producer feeding a branch
      present(I_ADDI, s);
      present(I_BEQ, s);
      chk("beq stalls", 32'(s), FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      chk("beq fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
      chk("beq fwd_b", 32'(fwd_b), 32'd0);
      sync(); idle(3);

      // asynchronous reset during the first stall cycle
      present(I_LW, s);
      id_ir = I_ADD2; id_valid = 1;
      @(negedge clk);
      chk("pre-rst stall pc_we", 32'(pc_we), 32'd0);
      #1 rst = 1;
      #1;
      chk("rst fwd_a", 32'(fwd_a), 32'd0);
      chk("rst fwd_b", 32'(fwd_b), 32'd0);
      chk("rst pc_we", 32'(pc_we), 32'd0);
      chk("rst bubble", 32'(idex_bubble), 32'd1);
      chk("rst flush", 32'(ifid_flush), 32'd0);
      #1 rst = 0;
      #1;
      chk("post-rst pc_we", 32'(pc_we), 32'd1);
      chk("post-rst ifid_we", 32'(ifid_we), 32'd1);
      chk("post-rst bubble", 32'(idex_bubble), 32'd0);
      sync();
      id_valid = 0;
      @(negedge clk);
      chk("post-rst fwd_a", 32'(fwd_a), 32'd0);
      sync();
      present(I_ADD2, s);
      chk("re-present stalls", 32'(s), 32'd0);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
